// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-enabled data RAM with fixed-latency req/gnt/rvalid responses
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  stall_i,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [DATA_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o
);
  logic                          w_acc;
  logic                          w_st;
  logic [DEPTH_LOG2-1:0]         w_idx;
  logic [DATA_WIDTH-1:0]         w_rd;
  logic [LATENCY-1:0]            w_vld_n;
  logic [LATENCY-1:0]            w_we_n;
  logic [LATENCY*DATA_WIDTH-1:0] w_dat_n;
  logic                          w_unused;
  logic [DATA_WIDTH-1:0]         r_mem [2**DEPTH_LOG2];
  logic [LATENCY-1:0]            r_vld;
  logic [LATENCY-1:0]            r_we;
  logic [LATENCY*DATA_WIDTH-1:0] r_dat;
  assign data_gnt_o = data_req_i & ~stall_i & rst_ni;
  assign w_acc      = data_gnt_o;
  assign w_st       = w_acc & data_we_i;
  assign w_idx      = data_addr_i[DEPTH_LOG2+1:2];
  assign w_unused   = ^{data_addr_i[DATA_WIDTH-1:DEPTH_LOG2+2], data_addr_i[1:0]};
  // loads sample the array at the acceptance edge; stores carry a zero word
  assign w_rd       = (w_acc & ~data_we_i) ? r_mem[w_idx] : '0;
  if (LATENCY == 1) begin : g_one
    assign w_vld_n = w_acc;
    assign w_we_n  = data_we_i;
    assign w_dat_n = w_rd;
  end else begin : g_shift
    assign w_vld_n = {r_vld[LATENCY-2:0], w_acc};
    assign w_we_n  = {r_we[LATENCY-2:0], data_we_i};
    assign w_dat_n = {r_dat[(LATENCY-1)*DATA_WIDTH-1:0], w_rd};
  end
  // byte-lane writes; contents deliberately survive reset
  always_ff @(posedge clk_i) begin
    for (int n = 0; n < 4; n++)
      if (w_st && data_be_i[n]) r_mem[w_idx][8*n +: 8] <= data_wdata_i[8*n +: 8];
  end
  // response shift register, flushed by reset so in-flight responses are dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld <= '0;
      r_we  <= '0;
      r_dat <= '0;
    end else begin
      r_vld <= w_vld_n;
      r_we  <= w_we_n;
      r_dat <= w_dat_n;
    end
  end
  assign data_rvalid_o = r_vld[LATENCY-1];
  assign data_rdata_o  = (r_vld[LATENCY-1] & ~r_we[LATENCY-1]) ? r_dat[LATENCY*DATA_WIDTH-1 -: DATA_WIDTH] : '0;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed bench with a queue-based response model for LATENCY 1 and 3
module tb_data_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n, stall, req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt1, rv1, gnt3, rv3;
  logic [31:0] rd1, rd3;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct {int due; logic [31:0] d;} ent_t;
  ent_t q1[$];
  ent_t q3[$];
  logic [31:0] mm [1024];
  int          m_idx;
  logic [31:0] m_d;
  logic        ev1, ev3;

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .data_req_i(req), .data_gnt_o(gnt1),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(rv1), .data_rdata_o(rd1));
  data_mem_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(3)) u_l3 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .data_req_i(req), .data_gnt_o(gnt3),
    .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
    .data_rvalid_o(rv3), .data_rdata_o(rd3));

  function automatic logic [31:0] z(input logic b);
    return {31'b0, b};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1'b1; we = w; addr = a; wdata = d; be = b; stall = 1'b0;
    step();
  endtask

  // model: each accepted request is due L-1 cycles after its acceptance edge
  always @(posedge clk) begin
    cyc++;
    if (rst_n && req && !stall) begin
      m_idx = int'((addr >> 2) % 32'd1024);
      m_d = 32'h0;
      if (we) begin
        for (int n = 0; n < 4; n++)
          if (be[n]) mm[m_idx][8*n +: 8] = wdata[8*n +: 8];
      end else m_d = mm[m_idx];
      q1.push_back('{cyc, m_d});
      q3.push_back('{cyc + 2, m_d});
    end
  end

  always @(negedge rst_n) begin
    q1.delete();
    q3.delete();
  end

  // per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    chk("gnt1", z(gnt1), z(req & ~stall & rst_n));
    chk("gnt3", z(gnt3), z(req & ~stall & rst_n));
    ev1 = (q1.size() > 0) && (q1[0].due == cyc);
    ev3 = (q3.size() > 0) && (q3[0].due == cyc);
    chk("rvalid1", z(rv1), z(ev1));
    chk("rdata1", rd1, ev1 ? q1[0].d : 32'h0);
    chk("rvalid3", z(rv3), z(ev3));
    chk("rdata3", rd3, ev3 ? q3[0].d : 32'h0);
    if (ev1) void'(q1.pop_front());
    if (ev3) void'(q3.pop_front());
  end

  logic [31:0] seen[$];
  int          at[$];
  int          k0;

  initial begin
    for (int i = 0; i < 1024; i++) mm[i] = 32'h0;
    rst_n = 1'b0; stall = 1'b0; req = 1'b1; we = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'hF;
    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt", z(gnt1), 32'h0);
      chk("rst_rvalid", z(rv1 | rv3), 32'h0);
      chk("rst_rdata", rd1 | rd3, 32'h0);
    end
    step();
    rst_n = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF; be = 4'hF;
    @(negedge clk);
    chk("release_gnt", z(gnt1), 32'h1);
    step();
    we = 1'b0;
    @(negedge clk);
    chk("st_resp_v", z(rv1), 32'h1);
    chk("st_resp_d", rd1, 32'h0);
    step();
    req = 1'b0;
    @(negedge clk);
    chk("ld_resp", rd1, 32'hDEADBEEF);
    step();
    xact(1'b1, 32'h12, 32'h000000AA, 4'b0001);
    xact(1'b1, 32'h12, 32'h55000000, 4'b1000);
    xact(1'b0, 32'h10, 32'h0, 4'b0000);
    req = 1'b0;
    @(negedge clk);
    chk("byte_en", rd1, 32'h55ADBEAA);
    step();
    req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h99999999; be = 4'hF; stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_gnt", z(gnt1), 32'h0);
      step();
      wdata = wdata + 32'h1;
    end
    req = 1'b0; stall = 1'b0;
    step();
    xact(1'b0, 32'h10, 32'h0, 4'hF);
    req = 1'b0;
    @(negedge clk);
    chk("withdrawn", rd1, 32'h55ADBEAA);
    step();
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h0BADF00D; stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_gnt", z(gnt1), 32'h0);
      step();
      wdata = wdata ^ 32'h0000FFFF;
    end
    stall = 1'b0; wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("unstall_gnt", z(gnt1), 32'h1);
    step();
    req = 1'b0;
    @(negedge clk);
    chk("unstall_rv", z(rv1), 32'h1);
    step();
    @(negedge clk);
    chk("single_rv", z(rv1), 32'h0);
    step();
    xact(1'b0, 32'h20, 32'h0, 4'hF);
    req = 1'b0;
    @(negedge clk);
    chk("stall_data", rd1, 32'hCAFEF00D);
    step();
    for (int i = 0; i < 4; i++) xact(1'b1, 32'h40 + 32'(4 * i), 32'(i + 1), 4'hF);
    req = 1'b0;
    repeat (4) step();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          xact(1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'hF);
          if (i == 0) k0 = cyc;
        end
        req = 1'b0;
      end
      begin
        repeat (10) begin
          @(negedge clk);
          if (rv3) begin
            seen.push_back(rd3);
            at.push_back(cyc);
          end
        end
      end
    join
    chk("pipe_count", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("pipe_data", seen[i], 32'(i + 1));
      chk("pipe_first", 32'(at[0] - k0), 32'd2);
      chk("pipe_span", 32'(at[3] - at[0]), 32'd3);
    end
    xact(1'b1, 32'h1004, 32'h12345678, 4'hF);
    xact(1'b0, 32'h0004, 32'h0, 4'hF);
    req = 1'b0;
    @(negedge clk);
    chk("wrap", rd1, 32'h12345678);
    step();
    xact(1'b0, 32'h0004, 32'h0, 4'hF);
    xact(1'b0, 32'h1004, 32'h0, 4'hF);
    rst_n = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("rst_drop", z(rv1 | rv3), 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    xact(1'b0, 32'h1004, 32'h0, 4'hF);
    req = 1'b0;
    @(negedge clk);
    chk("retained", rd1, 32'h12345678);
    repeat (5) step();
    chk("drain", 32'(q1.size() + q3.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's data memory interface: accepts req/gnt-handshaked loads and stores from the MEM-stage load/store unit, performs byte-enabled writes into an internal word array, and returns read data with a fixed, parameterised latency via rvalid. Used as the data RAM in the CPU top-level and in stage-level benches. A stall input throttles grants, so initiator wait behaviour can be exercised.

## Interface

- DATA_WIDTH, 32, data and address width; must be 32.
- DEPTH_LOG2, 10, log2 of the word count (default 1024 words = 4 KiB).
- LATENCY, 1, cycles from the acceptance edge to rvalid; legal range 1..4.

- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- stall_i  in  1  when 1, gnt is withheld
- data_req_i  in  1  request valid, held by the initiator until granted
- data_gnt_o  out  1  request accepted this cycle
- data_addr_i  in  DATA_WIDTH  byte address
- data_we_i  in  1  1 = store, 0 = load
- data_be_i  in  4  byte-lane enables, bit n = byte [8n+7:8n]
- data_wdata_i  in  DATA_WIDTH  store data, already lane-aligned
- data_rvalid_o  out  1  response valid, one pulse per accepted request
- data_rdata_o  out  DATA_WIDTH  load data, full word

## Operation

- Grant is combinational: data_gnt_o = data_req_i & ~stall_i & reset released.
- Acceptance occurs in any cycle with req & gnt. At most one transaction is accepted per cycle.
- Back-to-back acceptance every cycle is supported; there is no limit on outstanding requests other than the pipeline depth.
- Word index is data_addr_i[DEPTH_LOG2+1:2].
  - addr[1:0] are ignored.
  - Upper address bits are ignored, so addresses wrap modulo 4·2^DEPTH_LOG2.
- Store:
  - Written at the acceptance clock edge.
  - Only lanes with data_be_i[n]=1 are updated; other lanes are unchanged.
  - be = 4'b0000 is a legal no-op write and still produces a response.
- Load:
  - The array is sampled at the acceptance edge.
  - The full word is returned regardless of data_be_i; sign/zero extension and lane extraction belong to the LSU.
- A load accepted in the cycle after a store to the same word returns the updated data; there is no stale read.
- Response pipeline:
  - A LATENCY-deep shift register carries {valid, we, word}.
  - Every accepted request, load or store, yields exactly one rvalid pulse, in acceptance order.
- Store responses: rvalid=1 with rdata=0.
- Whenever rvalid=0, data_rdata_o is 0.
- stall_i only affects new grants. In-flight responses still complete on schedule.
- Memory contents are not reset and retain their value across rst_ni assertion. The simulation model initialises them to 0.

## Timing

- Reset values: data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, response pipeline cleared.
- Reset mid-operation:
  - In-flight responses are dropped; no rvalid follows after release.
  - Stores accepted before the reset edge remain in the array.
- Latency: request accepted at edge k produces rvalid high in the cycle following edge k+LATENCY-1.
  - With LATENCY=1, rvalid is high in the cycle immediately after the grant cycle.
- Throughput: 1 transaction per cycle when stall_i=0.
- Handshake: addr, we, be and wdata are sampled only in the acceptance cycle. Changes while ungranted are not observed.
- A request deasserted before grant has no effect.
- Simultaneous response output and new acceptance in the same cycle is normal and requires no arbitration.

## Test plan

- Reset, LATENCY=1: hold rst_ni=0 with req=1 → gnt=0, rvalid=0, rdata=0. Release → gnt=1 in the same cycle as req.
- Store then load: store 0xDEADBEEF, be=4'hF, addr 0x10; next cycle load addr 0x10 → two rvalid pulses on consecutive cycles; second carries rdata=0xDEADBEEF, first carries rdata=0.
- Byte enables: after the above, store 0x000000AA with be=4'b0001 and 0x55000000 with be=4'b1000 to 0x12 (same word) → load of 0x10 returns 0x55ADBEAA.
- Stall: req=1, stall_i=1 for 3 cycles then 0 → gnt stays 0 for 3 cycles and there are no writes. Then one grant and exactly one rvalid LATENCY cycles later.
- Pipelining, LATENCY=3: 4 back-to-back loads of words preloaded with 1, 2, 3, 4 → rvalid high for 4 consecutive cycles starting 3 cycles after the first grant; rdata 1, 2, 3, 4 in order.
- Wrap and reset: with DEPTH_LOG2=10, store 0x12345678 to 0x1004, then load 0x0004 → 0x12345678. Assert rst_ni with 2 loads in flight → no rvalid after release, and the array keeps 0x12345678.
